div_sqrt_preprocess_tp: RTL
===========================

Name: div_sqrt_preprocess_tp

Overview:
Operand preprocessing stage directly upstream of the single-precision iterative div/sqrt core. It accepts two IEEE-754 binary32 operands plus an operation select, and screens special cases (NaN/Inf/zero, invalid, divide-by-zero). It normalises denormal mantissas to a leading-one-at-bit-23 form with an extended exponent. Results are held in a one-entry output register with valid/ready handshakes on both sides. Special-case results bypass the iterative core.

Parameters:
C_OP, 32, operand width (binary32)
C_MANT, 23, stored mantissa width
C_EXP, 8, exponent field width
C_EXP_EXT, 10, two's-complement width of normalised biased exponent

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  synchronous active-low reset
Kill_SI  in  1  synchronous flush: drops held entry
In_valid_SI  in  1  upstream operands valid
In_ready_SO  out  1  stage can accept
Operand_a_DI  in  32  dividend / radicand
Operand_b_DI  in  32  divisor (ignored for sqrt)
Sqrt_SI  in  1  1=sqrt, 0=div
RM_SI  in  2  rounding mode (0 nearest, 1 trunc, 2 +inf, 3 -inf), passed through
Out_valid_SO  out  1  output entry valid
Out_ready_SI  in  1  core accepts
Mant_a_DO  out  24  normalised mantissa A, bit 23 = 1 unless zero
Mant_b_DO  out  24  normalised mantissa B
Exp_a_DO  out  10  biased exponent A after normalisation, signed
Exp_b_DO  out  10  biased exponent B after normalisation, signed
Sign_DO  out  1  result sign
Sqrt_SO  out  1  registered op select
RM_SO  out  2  registered rounding mode
Special_SO  out  1  result fully determined here; core must not iterate
Special_res_DO  out  32  special-case result value
NV_SO  out  1  invalid-operation flag
DZ_SO  out  1  divide-by-zero flag

Behaviour:
- Reset (Rst_RBI=0 at posedge): Out_valid_SO=0. All data outputs are 0: mantissas, exponents, Sign, Sqrt, RM, Special, Special_res, NV, DZ.
- Handshake: In_ready_SO = !Out_valid_SO | Out_ready_SI, combinational. Input transfer on In_valid_SI & In_ready_SO; output transfer on Out_valid_SO & Out_ready_SI.
- Latency 1 cycle: data accepted at edge N is visible with Out_valid_SO=1 after edge N.
- Simultaneous pop and push in the same cycle: the register reloads and Out_valid_SO stays 1, giving full throughput.
- Without an input transfer, Out_valid_SO clears on pop. Outputs remain stable while Out_valid_SO & !Out_ready_SI.
- Kill_SI=1: Out_valid_SO clears at the next edge and the concurrent input is discarded. Kill has priority over push. Reset has priority over kill.
- Normal operand, exp field e in 1..254: mant = {1, frac}, exp = e.
- Denormal operand, e=0, frac≠0: let lz = leading zeros of frac within 23 bits. mant = {1, frac} shifted left by lz+1 with the top bit dropped, so bit 23 is 1. exp = 1 - (lz+1), range -22..0.
- Zero operand: mant = 0, exp = 0.
- Sign: div gives sA^sB; sqrt gives sA.
- Special result for div, priority order:
  - any NaN -> 0x7FC00000; NV=1 if either operand is sNaN (exp ff, frac≠0, frac[22]=0).
  - Inf/Inf or 0/0 -> 0x7FC00000, NV=1.
  - Inf/x -> signed Inf.
  - x/0 with x finite nonzero -> signed Inf, DZ=1.
  - 0/x or x/Inf -> signed zero.
- Special result for sqrt:
  - NaN -> 0x7FC00000, NV on sNaN.
  - -0 -> 0x80000000.
  - other negative, including -Inf -> 0x7FC00000, NV=1.
  - +Inf -> 0x7F800000.
  - +0 -> 0x00000000.
- Special_SO=1 exactly in the cases above. NV/DZ are 0 otherwise. In special cases mantissa/exponent outputs are still computed but have no meaning.

Test Plan:
- Div 0x3F800000 / 0x40000000 -> after 1 cycle Mant_a=0x800000, Exp_a=127, Mant_b=0x800000, Exp_b=128, Sign=0, Special=0.
- Sqrt of denormal 0x00000001 -> Mant_a=0x800000, Exp_a=-22 (10'h3EA), Special=0; 0x00400000 -> Exp_a=0.
- Div 0x3F800000 / 0x80000000 -> Special=1, Special_res=0xFF800000, DZ=1, NV=0; 0/0 -> 0x7FC00000, NV=1; sqrt(0xBF800000) -> 0x7FC00000, NV=1; sqrt(0x80000000) -> 0x80000000, NV=0.
- Div with sNaN 0x7F800001 -> 0x7FC00000, NV=1; with qNaN 0x7FC00001 -> NV=0.
- Backpressure: Out_ready_SI=0 for 3 cycles with In_valid_SI=1 -> In_ready_SO=0, outputs frozen. Release with push -> back-to-back transfers one per cycle, no loss or duplication.
- Kill asserted with Out_valid=1 and concurrent push -> next cycle Out_valid=0, pushed data dropped. Reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/div_sqrt_preprocess_tp.sv
// Operand preprocessing ahead of the iterative binary32 div/sqrt core.
// Classifies both operands, resolves special cases (NaN/Inf/zero, invalid,
// divide-by-zero) locally, normalises denormals so the mantissa always has
// its leading one at bit 23, and holds the result in a one-entry
// valid/ready register.
module div_sqrt_preprocess_tp #(
    parameter int C_OP      = 32,
    parameter int C_MANT    = 23,
    parameter int C_EXP     = 8,
    parameter int C_EXP_EXT = 10
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    input  logic                 Kill_SI,
    input  logic                 In_valid_SI,
    output logic                 In_ready_SO,
    input  logic [C_OP-1:0]      Operand_a_DI,
    input  logic [C_OP-1:0]      Operand_b_DI,
    input  logic                 Sqrt_SI,
    input  logic [1:0]           RM_SI,
    output logic                 Out_valid_SO,
    input  logic                 Out_ready_SI,
    output logic [C_MANT:0]      Mant_a_DO,
    output logic [C_MANT:0]      Mant_b_DO,
    output logic [C_EXP_EXT-1:0] Exp_a_DO,
    output logic [C_EXP_EXT-1:0] Exp_b_DO,
    output logic                 Sign_DO,
    output logic                 Sqrt_SO,
    output logic [1:0]           RM_SO,
    output logic                 Special_SO,
    output logic [C_OP-1:0]      Special_res_DO,
    output logic                 NV_SO,
    output logic                 DZ_SO
);

    localparam int LZW = $clog2(C_MANT + 1);
    localparam logic [C_OP-1:0] QNAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};
    localparam logic [C_OP-2:0] INF_MAG = {{C_EXP{1'b1}}, {C_MANT{1'b0}}};

    // Leading zeros of a stored fraction (only meaningful when nonzero).
    function automatic logic [LZW-1:0] lzc(input logic [C_MANT-1:0] f);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = C_MANT - 1; i >= 0; i--) begin
            if (!found) begin
                if (f[i]) found = 1'b1;
                else      n     = n + 1'b1;
            end
        end
        return n;
    endfunction

    // Returns {mantissa, exponent}. Denormals are shifted so the leading one
    // lands on bit C_MANT; the exponent drops by the same amount from 1.
    function automatic logic [C_MANT+C_EXP_EXT:0] normalise(input logic [C_OP-1:0] op);
        logic [C_EXP-1:0]     e;
        logic [C_MANT-1:0]    f;
        logic [LZW-1:0]       lz;
        logic [C_MANT:0]      m;
        logic [C_EXP_EXT-1:0] x;
        e  = op[C_OP-2 -: C_EXP];
        f  = op[C_MANT-1:0];
        lz = lzc(f);
        if (e != '0) begin
            m = {1'b1, f};
            x = C_EXP_EXT'(e);
        end else if (f != '0) begin
            m = {f, 1'b0} << lz;
            x = '0 - C_EXP_EXT'(lz);
        end else begin
            m = '0;
            x = '0;
        end
        return {m, x};
    endfunction

    logic sa, sb;
    logic a_nan, a_snan, a_inf, a_zero;
    logic b_nan, b_snan, b_inf, b_zero;

    assign sa     = Operand_a_DI[C_OP-1];
    assign sb     = Operand_b_DI[C_OP-1];
    assign a_nan  = (&Operand_a_DI[C_OP-2 -: C_EXP]) & (|Operand_a_DI[C_MANT-1:0]);
    assign a_snan = a_nan & ~Operand_a_DI[C_MANT-1];
    assign a_inf  = (&Operand_a_DI[C_OP-2 -: C_EXP]) & ~(|Operand_a_DI[C_MANT-1:0]);
    assign a_zero = ~(|Operand_a_DI[C_OP-2:0]);
    assign b_nan  = (&Operand_b_DI[C_OP-2 -: C_EXP]) & (|Operand_b_DI[C_MANT-1:0]);
    assign b_snan = b_nan & ~Operand_b_DI[C_MANT-1];
    assign b_inf  = (&Operand_b_DI[C_OP-2 -: C_EXP]) & ~(|Operand_b_DI[C_MANT-1:0]);
    assign b_zero = ~(|Operand_b_DI[C_OP-2:0]);

    logic [C_MANT+C_EXP_EXT:0] norm_a_d, norm_b_d;
    logic                      sign_d, spec_d, nv_d, dz_d;
    logic [C_OP-1:0]           res_d;

    assign norm_a_d = normalise(Operand_a_DI);
    assign norm_b_d = normalise(Operand_b_DI);

    // Special-case screening in priority order; result bypasses the core.
    always_comb begin
        spec_d = 1'b0;
        res_d  = '0;
        nv_d   = 1'b0;
        dz_d   = 1'b0;
        sign_d = Sqrt_SI ? sa : (sa ^ sb);
        if (Sqrt_SI) begin
            if (a_nan) begin
                spec_d = 1'b1; res_d = QNAN; nv_d = a_snan;
            end else if (a_zero) begin
                spec_d = 1'b1; res_d = {sa, {(C_OP-1){1'b0}}};
            end else if (sa) begin
                spec_d = 1'b1; res_d = QNAN; nv_d = 1'b1;
            end else if (a_inf) begin
                spec_d = 1'b1; res_d = {1'b0, INF_MAG};
            end
        end else begin
            if (a_nan | b_nan) begin
                spec_d = 1'b1; res_d = QNAN; nv_d = a_snan | b_snan;
            end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
                spec_d = 1'b1; res_d = QNAN; nv_d = 1'b1;
            end else if (a_inf) begin
                spec_d = 1'b1; res_d = {sign_d, INF_MAG};
            end else if (b_zero) begin
                spec_d = 1'b1; res_d = {sign_d, INF_MAG}; dz_d = 1'b1;
            end else if (a_zero | b_inf) begin
                spec_d = 1'b1; res_d = {sign_d, {(C_OP-1){1'b0}}};
            end
        end
    end

    logic                 valid_q, valid_d, push, pop;
    logic [C_MANT:0]      mant_a_q, mant_b_q;
    logic [C_EXP_EXT-1:0] exp_a_q, exp_b_q;
    logic                 sign_q, sqrt_q, spec_q, nv_q, dz_q;
    logic [1:0]           rm_q;
    logic [C_OP-1:0]      res_q;

    assign In_ready_SO = ~valid_q | Out_ready_SI;
    assign push        = In_valid_SI & In_ready_SO & ~Kill_SI;
    assign pop         = valid_q & Out_ready_SI;

    // Occupancy: kill flushes, push (re)loads, pop alone empties.
    always_comb begin
        valid_d = valid_q;
        if (Kill_SI)   valid_d = 1'b0;
        else if (push) valid_d = 1'b1;
        else if (pop)  valid_d = 1'b0;
    end

    // One-entry output register; data only changes on an accepted push.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            valid_q  <= 1'b0;
            mant_a_q <= '0;
            mant_b_q <= '0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            sign_q   <= 1'b0;
            sqrt_q   <= 1'b0;
            rm_q     <= '0;
            spec_q   <= 1'b0;
            res_q    <= '0;
            nv_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (push) begin
                {mant_a_q, exp_a_q} <= norm_a_d;
                {mant_b_q, exp_b_q} <= norm_b_d;
                sign_q <= sign_d;
                sqrt_q <= Sqrt_SI;
                rm_q   <= RM_SI;
                spec_q <= spec_d;
                res_q  <= res_d;
                nv_q   <= nv_d;
                dz_q   <= dz_d;
            end
        end
    end

    assign Out_valid_SO   = valid_q;
    assign Mant_a_DO      = mant_a_q;
    assign Mant_b_DO      = mant_b_q;
    assign Exp_a_DO       = exp_a_q;
    assign Exp_b_DO       = exp_b_q;
    assign Sign_DO        = sign_q;
    assign Sqrt_SO        = sqrt_q;
    assign RM_SO          = rm_q;
    assign Special_SO     = spec_q;
    assign Special_res_DO = res_q;
    assign NV_SO          = nv_q;
    assign DZ_SO          = dz_q;

endmodule
